// File: rtl/btb_assoc_if.sv
// Fetch-side lookup, execute-side training and flush control for btb_assoc.
interface btb_assoc_if;
  logic [31:0] pc;
  logic        lookup_en;
  logic        update;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        flush;
  logic [31:0] target_pc;
  logic        valid;
  logic        predicted_taken;
  logic        busy;

  modport master (
    output pc, lookup_en, update, update_pc, update_taken, update_target, flush,
    input  target_pc, valid, predicted_taken, busy
  );
  modport slave (
    input  pc, lookup_en, update, update_pc, update_taken, update_target, flush,
    output target_pc, valid, predicted_taken, busy
  );
endinterface

// File: rtl/btb_assoc.sv
// N-way set-associative BTB: 2-bit direction counters, true-LRU ages,
// allocate-on-taken training and a one-set-per-cycle flush walker.
module btb_assoc #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input logic        clk,
  input logic        rst,
  btb_assoc_if.slave bus
);
  localparam int IDX = $clog2(SETS);
  localparam int WB  = $clog2(WAYS);
  localparam int TW  = 30 - IDX;

  typedef logic [WAYS-1:0][WB-1:0] ages_t;
  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t           state_q;
  logic [IDX-1:0]   ptr_q;
  logic [WAYS-1:0]  vld_q [SETS];
  ages_t            age_q [SETS];
  logic [TW-1:0]    tag_q [SETS][WAYS];
  logic [31:0]      tgt_q [SETS][WAYS];
  logic [1:0]       ctr_q [SETS][WAYS];

  logic [IDX-1:0]   lidx, uidx;
  logic [TW-1:0]    ltag, utag;
  logic [WAYS-1:0]  lhit, uhit;
  logic [WB-1:0]    lway, uway, inv_way, lru_way, vway, tway;
  logic             inv_found, idle, upd_go, up_touch, lk_touch;
  logic             unused_pc_lsb;

  assign lidx = bus.pc[IDX+1:2];
  assign ltag = bus.pc[31:IDX+2];
  assign uidx = bus.update_pc[IDX+1:2];
  assign utag = bus.update_pc[31:IDX+2];
  assign unused_pc_lsb = ^{bus.pc[1:0], bus.update_pc[1:0]};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign lhit[w] = vld_q[lidx][w] && (tag_q[lidx][w] == ltag);
    assign uhit[w] = vld_q[uidx][w] && (tag_q[uidx][w] == utag);
  end

  always_comb begin
    lway      = '0;
    uway      = '0;
    inv_way   = '0;
    lru_way   = '0;
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (lhit[w]) lway = WB'(w);
      if (uhit[w]) uway = WB'(w);
      if (age_q[uidx][w] == WB'(WAYS-1)) lru_way = WB'(w);
    end
    // descending scan so the lowest-index invalid way is the last one written
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!vld_q[uidx][w]) begin
        inv_way   = WB'(w);
        inv_found = 1'b1;
      end
    end
  end

  assign vway     = inv_found ? inv_way : lru_way;
  assign tway     = (|uhit) ? uway : vway;
  assign idle     = (state_q == S_IDLE);
  assign upd_go   = bus.update && idle;
  assign up_touch = upd_go && ((|uhit) || bus.update_taken);
  assign lk_touch = idle && bus.lookup_en && (|lhit) && !(up_touch && (uidx == lidx));

  assign bus.valid           = idle && (|lhit);
  assign bus.predicted_taken = bus.valid && ctr_q[lidx][lway][1];
  assign bus.target_pc       = bus.valid ? tgt_q[lidx][lway] : 32'h0;
  assign bus.busy            = !idle;

  function automatic ages_t touch(input ages_t a, input logic [WB-1:0] w);
    ages_t r;
    r = a;
    for (int i = 0; i < WAYS; i++)
      if (a[i] < a[w]) r[i] = a[i] + WB'(1);
    r[w] = '0;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WB'(w);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (up_touch) begin
            age_q[uidx] <= touch(age_q[uidx], tway);
            if (!(|uhit)) vld_q[uidx][vway] <= 1'b1;
          end
          if (lk_touch) age_q[lidx] <= touch(age_q[lidx], lway);
          if (bus.flush) begin
            state_q <= S_FLUSH;
            ptr_q   <= '0;
          end
        end
        S_FLUSH: begin
          vld_q[ptr_q] <= '0;
          for (int w = 0; w < WAYS; w++) age_q[ptr_q][w] <= WB'(w);
          ptr_q <= ptr_q + IDX'(1);
          if (ptr_q == IDX'(SETS-1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // payload storage carries no reset; valid bits gate every use of it
  always_ff @(posedge clk) begin
    if (upd_go) begin
      if (|uhit) begin
        if (bus.update_taken) begin
          if (ctr_q[uidx][uway] != 2'b11) ctr_q[uidx][uway] <= ctr_q[uidx][uway] + 2'b01;
          tgt_q[uidx][uway] <= bus.update_target;
        end else if (ctr_q[uidx][uway] != 2'b00) begin
          ctr_q[uidx][uway] <= ctr_q[uidx][uway] - 2'b01;
        end
      end else if (bus.update_taken) begin
        tag_q[uidx][vway] <= utag;
        tgt_q[uidx][vway] <= bus.update_target;
        ctr_q[uidx][vway] <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: a 2-way and a 4-way instance share one stimulus stream.
module tb_btb_assoc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  btb_assoc_if b2();
  btb_assoc_if b4();

  assign b4.pc            = b2.pc;
  assign b4.lookup_en     = b2.lookup_en;
  assign b4.update        = b2.update;
  assign b4.update_pc     = b2.update_pc;
  assign b4.update_taken  = b2.update_taken;
  assign b4.update_target = b2.update_target;
  assign b4.flush         = b2.flush;

  btb_assoc #(.SETS(8), .WAYS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  btb_assoc #(.SETS(8), .WAYS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tg);
    b2.update        = 1'b1;
    b2.update_pc     = a;
    b2.update_taken  = t;
    b2.update_target = tg;
    step();
    b2.update = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a);
    b2.pc        = a;
    b2.lookup_en = 1'b0;
    step();
  endtask

  task automatic touch(input logic [31:0] a);
    b2.pc        = a;
    b2.lookup_en = 1'b1;
    step();
    b2.lookup_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (b2.busy && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    b2.pc = 32'h100; b2.lookup_en = 0; b2.update = 0; b2.update_pc = 0;
    b2.update_taken = 0; b2.update_target = 0; b2.flush = 0;
    #12 rst = 1'b1;
    step();

    check("rst_valid", b2.valid, 0);
    check("rst_busy",  b2.busy, 0);
    check("rst_pt",    b2.predicted_taken, 0);
    check("rst_tgt",   b2.target_pc, 0);

    // allocation and counter hysteresis on 0x100
    upd(32'h100, 1, 32'h200);
    peek(32'h100);
    check("alloc_valid", b2.valid, 1);
    check("alloc_tgt",   b2.target_pc, 32'h200);
    check("alloc_pt",    b2.predicted_taken, 1);
    peek(32'h120);
    check("alias_miss",  b2.valid, 0);

    upd(32'h100, 0, 32'h999);
    peek(32'h100);
    check("nt1_valid", b2.valid, 1);
    check("nt1_pt",    b2.predicted_taken, 0);
    check("nt1_tgt",   b2.target_pc, 32'h200);
    upd(32'h100, 0, 32'h999);
    upd(32'h100, 0, 32'h999);
    upd(32'h100, 1, 32'h300);
    peek(32'h100);
    check("ctr_floor_pt", b2.predicted_taken, 0);
    check("t1_tgt",       b2.target_pc, 32'h300);
    upd(32'h100, 1, 32'h300);
    peek(32'h100);
    check("t2_pt", b2.predicted_taken, 1);
    upd(32'h100, 1, 32'h300);
    upd(32'h100, 1, 32'h300);
    upd(32'h100, 0, 32'h999);
    peek(32'h100);
    check("ctr_sat_pt", b2.predicted_taken, 1);
    upd(32'h100, 0, 32'h999);
    peek(32'h100);
    check("ctr_down_pt", b2.predicted_taken, 0);
    check("ctr_tgt",     b2.target_pc, 32'h300);

    upd(32'h180, 0, 32'h444);
    peek(32'h180);
    check("nt_miss_noalloc", b2.valid, 0);
    peek(32'h100);
    check("nt_miss_keep", b2.valid, 1);

    // 2-way LRU
    do_reset();
    peek(32'h100);
    check("rst2_valid", b2.valid, 0);
    upd(32'h100, 1, 32'h1100);
    upd(32'h120, 1, 32'h1200);
    touch(32'h100);
    upd(32'h140, 1, 32'h1400);
    peek(32'h120);
    check("lru2_evict", b2.valid, 0);
    peek(32'h100);
    check("lru2_keep_v", b2.valid, 1);
    check("lru2_keep_t", b2.target_pc, 32'h1100);
    peek(32'h140);
    check("lru2_new_v", b2.valid, 1);
    check("lru2_new_t", b2.target_pc, 32'h1400);

    // 4-way LRU: A..D fill, touch A then B, E must evict C
    do_reset();
    upd(32'h100, 1, 32'hA0);
    upd(32'h120, 1, 32'hB0);
    upd(32'h140, 1, 32'hC0);
    upd(32'h160, 1, 32'hD0);
    touch(32'h100);
    touch(32'h120);
    upd(32'h180, 1, 32'hE0);
    peek(32'h140);
    check("lru4_evict_c", b4.valid, 0);
    peek(32'h100);
    check("lru4_a", b4.target_pc, 32'hA0);
    peek(32'h120);
    check("lru4_b", b4.target_pc, 32'hB0);
    peek(32'h160);
    check("lru4_d", b4.target_pc, 32'hD0);
    peek(32'h180);
    check("lru4_e", b4.target_pc, 32'hE0);

    // flush
    do_reset();
    for (int s = 0; s < 8; s++) upd(32'h1000 + s*4, 1, 32'h2000 + s*4);
    peek(32'h1014);
    check("pre_flush_v", b2.valid, 1);
    check("pre_flush_t", b2.target_pc, 32'h2014);
    b2.flush = 1'b1;
    step();
    b2.flush = 1'b0;
    check("flush_busy",  b2.busy, 1);
    check("flush_valid", b2.valid, 0);
    check("flush_tgt",   b2.target_pc, 0);
    check("flush_pt",    b2.predicted_taken, 0);
    n = 0;
    while (b2.busy && n < 40) begin
      n++;
      b2.update        = (n == 3);
      b2.update_pc     = 32'h3000;
      b2.update_taken  = 1'b1;
      b2.update_target = 32'h3300;
      step();
    end
    b2.update = 1'b0;
    check("busy_cycles", n, 8);
    upd(32'h1000, 1, 32'h5000);
    for (int s = 1; s < 8; s++) begin
      peek(32'h1000 + s*4);
      check($sformatf("flushed_set%0d", s), b2.valid, 0);
    end
    peek(32'h3000);
    check("midflush_drop", b2.valid, 0);
    peek(32'h1000);
    check("post_flush_upd_v", b2.valid, 1);
    check("post_flush_upd_t", b2.target_pc, 32'h5000);
    upd(32'h1020, 1, 32'h5020);
    peek(32'h1000);
    check("realloc_w0", b2.valid, 1);
    upd(32'h1040, 1, 32'h5040);
    peek(32'h1000);
    check("realloc_evict", b2.valid, 0);
    peek(32'h1040);
    check("realloc_new", b2.target_pc, 32'h5040);

    // same-cycle update and lookup: no bypass
    b2.pc = 32'h1020;
    b2.update = 1; b2.update_pc = 32'h1020; b2.update_taken = 1; b2.update_target = 32'h6020;
    #1;
    check("sc_hit_old", b2.target_pc, 32'h5020);
    step();
    b2.update = 0;
    #1;
    check("sc_hit_new", b2.target_pc, 32'h6020);
    b2.pc = 32'h2004;
    b2.update = 1; b2.update_pc = 32'h2004; b2.update_target = 32'h2400;
    #1;
    check("sc_miss_old", b2.valid, 0);
    step();
    b2.update = 0;
    #1;
    check("sc_miss_new", b2.target_pc, 32'h2400);

    // flush and update in the same idle cycle
    b2.update = 1; b2.update_pc = 32'h2008; b2.update_taken = 1; b2.update_target = 32'h2800;
    b2.flush = 1;
    step();
    b2.update = 0; b2.flush = 0;
    check("fu_busy", b2.busy, 1);
    wait_idle(n);
    check("fu_cycles", n, 8);
    peek(32'h2008);
    check("fu_gone", b2.valid, 0);
    peek(32'h2004);
    check("fu_old_gone", b2.valid, 0);

    // async reset in the middle of a flush
    upd(32'h101C, 1, 32'h7000);
    b2.pc = 32'h101C;
    b2.flush = 1;
    step();
    b2.flush = 0;
    step();
    step();
    check("ar_busy_before", b2.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy", b2.busy, 0);
    check("ar_valid", b2.valid, 0);
    check("ar_tgt", b2.target_pc, 0);
    #3;
    rst = 1'b1;
    step();
    check("ar_idle", b2.busy, 0);
    upd(32'h101C, 1, 32'h7100);
    peek(32'h101C);
    check("ar_upd_v", b2.valid, 1);
    check("ar_upd_t", b2.target_pc, 32'h7100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised N-way set-associative branch target buffer with per-entry 2-bit saturating direction counters, true-LRU replacement and a multi-cycle flush engine. It sits in the fetch stage: it is looked up combinationally with the fetch PC, and it is trained from the execute stage with resolved branch outcomes. It succeeds the fixed 8-set BTB with a generalised geometry, allocate-on-taken policy and hysteresis on direction. It also adds a bulk-invalidate operation for fence/context-switch.

## Interface
- SETS, 8, number of sets; power of 2, ≥2; IDX = log2(SETS)
- WAYS, 2, associativity; power of 2, 2..8; WB = log2(WAYS)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pc  in  32  fetch PC to look up
- lookup_en  in  1  qualifies pc; when high, a lookup hit updates LRU
- update  in  1  training strobe for a resolved control-transfer instruction
- update_pc  in  32  PC of the resolved branch
- update_taken  in  1  resolved direction
- update_target  in  32  resolved target
- flush  in  1  start bulk invalidate (pulse)
- target_pc  out  32  predicted target; 0 when valid=0
- valid  out  1  lookup hit in a valid way
- predicted_taken  out  1  valid & counter[1] of the hit way
- busy  out  1  flush in progress

## Operation
- Address split: index = pc[IDX+1:2], tag = pc[31:IDX+2]; same split for update_pc.
- Entry = {valid, tag, target[31:0], ctr[1:0]}; per set, per way age[WB-1:0].
- Lookup: compare tag against all ways of the indexed set; at most one way can match (the allocation invariant guarantees it). On hit, outputs come from that way.
- Update hit (tag match in update set):
  - ctr is incremented, saturating at 3, if taken; otherwise it is decremented, saturating at 0.
  - target is overwritten with update_target only when taken.
  - That way becomes MRU.
- Update miss, taken: allocate. Victim = lowest-index invalid way, else the way with age == WAYS-1. Write valid=1, tag, target, ctr=2'b10; victim becomes MRU.
- Update miss, not-taken: no state change.
- LRU touch of way w: every way in the set with age < age[w] increments; age[w] ← 0. Ages in a set always form a permutation of 0..WAYS-1.
- Lookup-hit LRU touch happens only when lookup_en=1 and state is IDLE.
- When the lookup and the update hit the same set in one cycle, the update touch wins and the lookup touch is dropped.
- FSM states and transitions:
  - IDLE → FLUSH on flush=1; the set pointer resets to 0.
  - In FLUSH, each cycle clears valid in all ways of the current set, resets its ages to age[w]=w, and increments the pointer.
  - FLUSH → IDLE after the cycle that clears set SETS-1.
- While in FLUSH:
  - busy=1.
  - valid, predicted_taken = 0 and target_pc = 0.
  - update is ignored (dropped, not queued).
  - flush is ignored.
- Reset (async, any state including mid-flush):
  - All valid bits are 0, ages age[w]=w, FSM IDLE, pointer 0.
  - Outputs: valid=0, predicted_taken=0, target_pc=0, busy=0.
  - Tag, target and ctr storage need not be reset.

## Timing
- Lookup: combinational, same cycle as pc.
- Update: committed at the clk edge where update=1; visible to lookups from the next cycle.
- No write-to-read bypass: a lookup in the update cycle sees pre-update contents.
- Flush: busy rises the cycle after flush is sampled and stays high exactly SETS cycles. The first post-flush update is accepted in the cycle busy reads 0.
- flush and update in the same IDLE cycle: the update is committed at that edge, then the flush begins and clears it.

## Test plan
- Allocation hit, SETS=8, WAYS=2:
  - Stimulus: update_pc=0x100, taken, target 0x200; then lookup pc=0x100.
  - Required: valid=1, target_pc=0x200, predicted_taken=1 (ctr=2).
  - A lookup of 0x120 (same index, different tag) gives valid=0.
- Hysteresis: starting from the entry above, apply two not-taken updates on 0x100.
  - After the first: valid=1, predicted_taken=0 (ctr=1).
  - After the second: ctr=0.
  - Then three taken updates with target 0x300: ctr saturates at 3, target_pc=0x300.
  - A not-taken update on a miss address allocates nothing.
- LRU eviction, WAYS=2:
  - Stimulus: allocate 0x100 then 0x120 (index 0); look up 0x100 with lookup_en=1; allocate 0x140.
  - Required: 0x120 is evicted, and 0x100 and 0x140 both hit.
  - Repeat with WAYS=4 and five tags; the victim is the least-recently-touched tag.
- Flush: populate all 8 sets, pulse flush.
  - busy=1 for exactly 8 cycles.
  - An update issued mid-flush is dropped.
  - After the flush, every lookup gives valid=0, then allocation restarts at way 0.
- Same-cycle update and lookup on the same pc:
  - The lookup returns old data, with the new data on the next cycle.
  - flush+update together: the entry is gone after the flush.
- Async reset asserted mid-flush (between edges): busy=0 and valid=0 immediately, FSM in IDLE; a normal update after reset release hits.
